rvc_compressor: RTL and testbench
=================================

Name: rvc_compressor

Overview:
- Streaming RV32IC instruction compressor. It is the inverse of the front-end RVC expansion path.
- Accepts one 32-bit RV32I instruction per handshake and re-encodes it as a 16-bit RVC instruction when an exact equivalent exists.
- Packs the resulting 16/32-bit parcels little-endian into aligned 32-bit words for the instruction-memory image writer.
- Branch/jump offsets are copied literally, never relocated. The producer guarantees offsets are valid for the packed layout.

Parameters:
- STATS_W, 16, width of optional statistics counters.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- inst_valid_in  input  1  input instruction valid
- inst_ready_out  output  1  block can accept an instruction
- inst_in  input  32  RV32I instruction
- flush_in  input  1  request to emit the pending halfword
- flush_ack_out  output  1  one-cycle pulse when the flush is accepted
- word_valid_out  output  1  packed word valid
- word_ready_in  input  1  consumer accepts word
- word_out  output  32  packed word; lower halfword = earlier parcel

Behaviour:
- Reset (async, rst_n_in=0): word_valid_out=0, word_out=0, flush_ack_out=0, hold_valid=0, hold=0. Takes effect immediately, including a pending halfword or a stalled word, which are discarded.
- inst_ready_out = !word_valid_out || word_ready_in (combinational). An accept happens when inst_valid_in && inst_ready_out.
- Compression is combinational on inst_in. The result is registered on accept. Latency is 1 cycle from accept to word_valid_out, where a word is produced.
- Compressible set (anything else, or inst_in[1:0]!=11, passes as a 32-bit parcel):
  - addi x0,x0,0 -> c.nop 0x0001.
  - addi rd=rs1!=0, imm!=0, imm in [-32,31] -> c.addi.
  - addi rs1=x0, rd!=0, imm in [-32,31] -> c.li.
  - add rd!=0, rs1=x0, rs2!=0 -> c.mv.
  - add rd=rs1!=0, rs2!=0 -> c.add.
  - sub/xor/or/and with rd=rs1 and rs2 in x8..x15 -> c.sub/c.xor/c.or/c.and.
  - andi rd=rs1 in x8..x15, imm in [-32,31] -> c.andi.
  - slli rd=rs1!=0, shamt 1..31 -> c.slli.
  - srli/srai rd=rs1 in x8..x15, shamt 1..31 -> c.srli/c.srai.
  - lw/sw with base x2, offset %4==0 in [0,252], lw rd!=0 -> c.lwsp/c.swsp.
  - lw/sw with base and data reg in x8..x15, offset %4==0 in [0,124] -> c.lw/c.sw.
  - jal rd in {x0,x1}, offset even in [-2048,2046] -> c.j/c.jal.
  - jalr rd in {x0,x1}, rs1!=0, imm=0 -> c.jr/c.jalr.
  - beq/bne rs2=x0, rs1 in x8..x15, offset even in [-256,254] -> c.beqz/c.bnez.
- Packing state (hold_valid, hold[15:0]), on accept:
  - empty + 16-bit parcel p: hold<=p, hold_valid<=1, no word.
  - empty + 32-bit parcel w: emit w.
  - full + 16-bit p: emit {p,hold}, hold_valid<=0.
  - full + 32-bit w: emit {w[15:0],hold}, hold<=w[31:16], hold_valid stays 1.
- Flush is accepted when flush_in && !inst_valid_in && inst_ready_out. inst_valid_in has priority and flush waits.
  - If hold_valid: emit {16'h0001,hold} and clear hold.
  - If empty: no word.
  - Either way, flush_ack_out=1 for the following cycle.
- Output register: word_valid_out clears on word_ready_in unless a new word is loaded the same cycle. word_out is stable while word_valid_out && !word_ready_in.

Optional Feature:
- Macro RVC_COMPRESSOR_STATS_EN.
- When defined, adds outputs n_in_out, n_comp_out, n_word_out, each STATS_W bits:
  - n_in_out counts accepted instructions.
  - n_comp_out counts instructions emitted as 16-bit parcels.
  - n_word_out counts word handshakes.
  - All saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- 0x00150513 then 0x00B50533, word_ready_in=1 -> single word 0x952E0505 one cycle after the second accept; hold empty.
- Hold empty, 0x123452B7 -> word 0x123452B7 next cycle.
- 0x00150513, then 0x123452B7, then flush_in -> words 0x52B70505 then 0x00011234; flush_ack_out pulses once.
- Boundaries:
  - beq x8,x0,+256 -> 32-bit parcel.
  - addi x10,x10,-32 -> c.addi 0x1501.
  - addi x10,x10,32 -> 32-bit parcel.
  - slli x5,x5,0 -> 32-bit parcel.
- word_ready_in=0 for 5 cycles with word pending -> inst_ready_out=0, word_out unchanged, no lost or duplicated words after release.
- rst_n_in low mid-stream with hold full and a word stalled -> word_valid_out=0 immediately; a following flush produces no word.

Source files
------------

// File: rtl/rvc_compressor_if.sv
// Handshake bundle for rvc_compressor: instruction input, flush request and packed word output.
// The slave modport is the compressor's view; master is the producer/consumer environment.
interface rvc_compressor_if;
   logic        inst_valid_in;
   logic        inst_ready_out;
   logic [31:0] inst_in;
   logic        flush_in;
   logic        flush_ack_out;
   logic        word_valid_out;
   logic        word_ready_in;
   logic [31:0] word_out;

   modport slave (
      input  inst_valid_in,
      input  inst_in,
      input  flush_in,
      input  word_ready_in,
      output inst_ready_out,
      output flush_ack_out,
      output word_valid_out,
      output word_out
   );

   modport master (
      output inst_valid_in,
      output inst_in,
      output flush_in,
      output word_ready_in,
      input  inst_ready_out,
      input  flush_ack_out,
      input  word_valid_out,
      input  word_out
   );
endinterface

// File: rtl/rvc_compressor.sv
// Streaming RV32I -> RV32IC compressor. Each accepted instruction is re-encoded as a 16-bit
// RVC parcel when an exact equivalent exists; parcels are packed little-endian into 32-bit
// words (lower halfword = earlier parcel). Branch/jump offsets are copied, never relocated.
// Optional statistics counters are enabled by defining RVC_COMPRESSOR_STATS_EN.
module rvc_compressor
`ifdef RVC_COMPRESSOR_STATS_EN
#(
   parameter int unsigned STATS_W = 16
)
`endif
(
   input  logic                 clk_in,
   input  logic                 rst_n_in,
`ifdef RVC_COMPRESSOR_STATS_EN
   output logic [STATS_W-1:0]   n_in_out,
   output logic [STATS_W-1:0]   n_comp_out,
   output logic [STATS_W-1:0]   n_word_out,
`endif
   rvc_compressor_if.slave      bus
);

   // Instruction fields
   logic [6:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [11:0] imm_i;
   logic [11:0] imm_s;
   logic [12:1] imm_b;
   logic [20:1] imm_j;
   logic        rd_p;
   logic        rs1_p;
   logic        rs2_p;
   logic        imm6_ok;

   // Compression result
   logic        is16;
   logic [15:0] c16;

   // Packing and output state
   logic        hold_valid_q, hold_valid_d;
   logic [15:0] hold_q, hold_d;
   logic        word_valid_q, word_valid_d;
   logic [31:0] word_q, word_d;
   logic        flush_ack_q, flush_ack_d;

   logic        accept;
   logic        flush_acc;

   assign op    = bus.inst_in[6:0];
   assign rd    = bus.inst_in[11:7];
   assign f3    = bus.inst_in[14:12];
   assign rs1   = bus.inst_in[19:15];
   assign rs2   = bus.inst_in[24:20];
   assign f7    = bus.inst_in[31:25];
   assign imm_i = bus.inst_in[31:20];
   assign imm_s = {bus.inst_in[31:25], bus.inst_in[11:7]};
   assign imm_b = {bus.inst_in[31], bus.inst_in[7], bus.inst_in[30:25], bus.inst_in[11:8]};
   assign imm_j = {bus.inst_in[31], bus.inst_in[19:12], bus.inst_in[20], bus.inst_in[30:21]};

   // x8..x15 are the registers addressable by the 3-bit RVC register fields
   assign rd_p    = (rd[4:3] == 2'b01);
   assign rs1_p   = (rs1[4:3] == 2'b01);
   assign rs2_p   = (rs2[4:3] == 2'b01);
   assign imm6_ok = (imm_i[11:5] == {7{imm_i[5]}});

   // Combinational RV32I -> RVC re-encoding; is16 low means pass the 32-bit word through
   always_comb begin
      is16 = 1'b0;
      c16  = 16'h0000;
      case (op)
         7'b0010011: begin
            case (f3)
               3'b000: begin
                  if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
                     is16 = 1'b1;
                     c16  = 16'h0001;
                  end else if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && imm6_ok) begin
                     is16 = 1'b1;
                     c16  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                  end else if (rs1 == 5'd0 && rd != 5'd0 && imm6_ok) begin
                     is16 = 1'b1;
                     c16  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                  end
               end
               3'b001: begin
                  if (f7 == 7'b0000000 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                     is16 = 1'b1;
                     c16  = {3'b000, 1'b0, rd, rs2, 2'b10};
                  end
               end
               3'b101: begin
                  if ((f7 == 7'b0000000 || f7 == 7'b0100000) && rd == rs1 && rd_p &&
                      rs2 != 5'd0) begin
                     is16 = 1'b1;
                     c16  = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
                  end
               end
               3'b111: begin
                  if (rd == rs1 && rd_p && imm6_ok) begin
                     is16 = 1'b1;
                     c16  = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
                  end
               end
               default: ;
            endcase
         end
         7'b0110011: begin
            if (f7 == 7'b0000000 && f3 == 3'b000) begin
               if (rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
                  is16 = 1'b1;
                  c16  = {4'b1000, rd, rs2, 2'b10};
               end else if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                  is16 = 1'b1;
                  c16  = {4'b1001, rd, rs2, 2'b10};
               end
            end else if (rd == rs1 && rd_p && rs2_p) begin
               if (f7 == 7'b0100000 && f3 == 3'b000) begin
                  is16 = 1'b1;
                  c16  = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
               end else if (f7 == 7'b0000000 && f3 == 3'b100) begin
                  is16 = 1'b1;
                  c16  = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
               end else if (f7 == 7'b0000000 && f3 == 3'b110) begin
                  is16 = 1'b1;
                  c16  = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
               end else if (f7 == 7'b0000000 && f3 == 3'b111) begin
                  is16 = 1'b1;
                  c16  = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
               end
            end
         end
         7'b0000011: begin
            if (f3 == 3'b010) begin
               if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'd0) begin
                  is16 = 1'b1;
                  c16  = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
               end else if (rs1_p && rd_p && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
                  is16 = 1'b1;
                  c16  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
               end
            end
         end
         7'b0100011: begin
            if (f3 == 3'b010) begin
               if (rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0) begin
                  is16 = 1'b1;
                  c16  = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
               end else if (rs1_p && rs2_p && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
                  is16 = 1'b1;
                  c16  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
               end
            end
         end
         7'b1101111: begin
            // c.j when rd=x0, c.jal when rd=x1
            if (rd[4:1] == 4'd0 && imm_j[20:11] == {10{imm_j[11]}}) begin
               is16 = 1'b1;
               c16  = {~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6],
                       imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
            end
         end
         7'b1100111: begin
            if (f3 == 3'b000 && rd[4:1] == 4'd0 && rs1 != 5'd0 && imm_i == 12'd0) begin
               is16 = 1'b1;
               c16  = {3'b100, rd[0], rs1, 5'd0, 2'b10};
            end
         end
         7'b1100011: begin
            // f3[0] selects bnez over beqz
            if (f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p && imm_b[12:8] == {5{imm_b[8]}}) begin
               is16 = 1'b1;
               c16  = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1],
                       imm_b[5], 2'b01};
            end
         end
         default: ;
      endcase
   end

   assign bus.inst_ready_out = !word_valid_q || bus.word_ready_in;
   assign accept             = bus.inst_valid_in && bus.inst_ready_out;
   assign flush_acc          = bus.flush_in && !bus.inst_valid_in && bus.inst_ready_out;

   // Halfword packing and output-register next state
   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      word_d       = word_q;
      word_valid_d = word_valid_q && !bus.word_ready_in;
      flush_ack_d  = flush_acc;
      if (accept) begin
         if (!hold_valid_q) begin
            if (is16) begin
               hold_d       = c16;
               hold_valid_d = 1'b1;
            end else begin
               word_d       = bus.inst_in;
               word_valid_d = 1'b1;
            end
         end else if (is16) begin
            word_d       = {c16, hold_q};
            word_valid_d = 1'b1;
            hold_valid_d = 1'b0;
         end else begin
            // Upper half of the 32-bit parcel spills into the next word
            word_d       = {bus.inst_in[15:0], hold_q};
            word_valid_d = 1'b1;
            hold_d       = bus.inst_in[31:16];
         end
      end else if (flush_acc && hold_valid_q) begin
         // Pad the odd halfword with c.nop
         word_d       = {16'h0001, hold_q};
         word_valid_d = 1'b1;
         hold_d       = 16'h0000;
         hold_valid_d = 1'b0;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hold_q       <= 16'h0000;
         hold_valid_q <= 1'b0;
         word_q       <= 32'h0000_0000;
         word_valid_q <= 1'b0;
         flush_ack_q  <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         flush_ack_q  <= flush_ack_d;
      end
   end

   assign bus.word_valid_out = word_valid_q;
   assign bus.word_out       = word_q;
   assign bus.flush_ack_out  = flush_ack_q;

`ifdef RVC_COMPRESSOR_STATS_EN
   localparam logic [STATS_W-1:0] StatsOne = {{(STATS_W-1){1'b0}}, 1'b1};

   logic [STATS_W-1:0] n_in_q, n_in_d;
   logic [STATS_W-1:0] n_comp_q, n_comp_d;
   logic [STATS_W-1:0] n_word_q, n_word_d;

   // Saturating event counters
   always_comb begin
      n_in_d   = n_in_q;
      n_comp_d = n_comp_q;
      n_word_d = n_word_q;
      if (accept && n_in_q != '1) begin
         n_in_d = n_in_q + StatsOne;
      end
      if (accept && is16 && n_comp_q != '1) begin
         n_comp_d = n_comp_q + StatsOne;
      end
      if (word_valid_q && bus.word_ready_in && n_word_q != '1) begin
         n_word_d = n_word_q + StatsOne;
      end
   end

   // Counter registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         n_in_q   <= '0;
         n_comp_q <= '0;
         n_word_q <= '0;
      end else begin
         n_in_q   <= n_in_d;
         n_comp_q <= n_comp_d;
         n_word_q <= n_word_d;
      end
   end

   assign n_in_out   = n_in_q;
   assign n_comp_out = n_comp_q;
   assign n_word_out = n_word_q;
`endif

endmodule

// File: tb/tb_rvc_compressor.sv
// Directed testbench for rvc_compressor with hand-computed expected words.
module tb_rvc_compressor;

   logic clk;
   logic rst_n;

   rvc_compressor_if bus ();

`ifdef RVC_COMPRESSOR_STATS_EN
   logic [15:0] n_in;
   logic [15:0] n_comp;
   logic [15:0] n_word;
`endif

   rvc_compressor u_dut (
      .clk_in     (clk),
      .rst_n_in   (rst_n),
`ifdef RVC_COMPRESSOR_STATS_EN
      .n_in_out   (n_in),
      .n_comp_out (n_comp),
      .n_word_out (n_word),
`endif
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_acks   = 0;
   logic [31:0] words[$];

   // Observe completed word handshakes and flush acks mid-cycle
   always @(negedge clk) begin
      if (rst_n && bus.word_valid_out && bus.word_ready_in) words.push_back(bus.word_out);
      if (rst_n && bus.flush_ack_out) n_acks++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Present one instruction and hold it until accepted; returns 1 time unit after the edge
   task automatic send(input logic [31:0] ins);
      int n;
      n = 0;
      bus.inst_in       = ins;
      bus.inst_valid_in = 1'b1;
      @(negedge clk);
      while (!bus.inst_ready_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_eq("send_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      bus.inst_valid_in = 1'b0;
   endtask

   task automatic do_flush();
      int n;
      n = 0;
      bus.flush_in = 1'b1;
      @(negedge clk);
      while (!bus.inst_ready_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_eq("flush_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      bus.flush_in = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   // One instruction followed by a flush always yields exactly one word
   task automatic run_vec(input string tag, input logic [31:0] ins, input logic [31:0] exp);
      words.delete();
      send(ins);
      do_flush();
      settle();
      check_eq({tag, "_cnt"}, 32'(words.size()), 32'd1);
      if (words.size() > 0) check_eq(tag, words[0], exp);
   endtask

   int acks0;

   initial begin
      rst_n             = 1'b0;
      bus.inst_valid_in = 1'b0;
      bus.inst_in       = 32'h0;
      bus.flush_in      = 1'b0;
      bus.word_ready_in = 1'b1;
      #12;
      check_eq("rst_word_valid", 32'(bus.word_valid_out), 32'd0);
      check_eq("rst_word", bus.word_out, 32'h0);
      check_eq("rst_flush_ack", 32'(bus.flush_ack_out), 32'd0);
      check_eq("rst_inst_ready", 32'(bus.inst_ready_out), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();

      // Two compressible instructions pack into one word
      words.delete();
      send(32'h0015_0513);
      check_eq("A_no_word_yet", 32'(bus.word_valid_out), 32'd0);
      send(32'h00B5_0533);
      check_eq("A_latency", 32'(bus.word_valid_out), 32'd1);
      check_eq("A_word_now", bus.word_out, 32'h952E_0505);
      settle();
      check_eq("A_cnt", 32'(words.size()), 32'd1);
      if (words.size() > 0) check_eq("A_word", words[0], 32'h952E_0505);
      send(32'h1234_52B7);
      check_eq("lui_latency", 32'(bus.word_valid_out), 32'd1);
      check_eq("lui_word_now", bus.word_out, 32'h1234_52B7);
      settle();
      acks0 = n_acks;
      do_flush();
      settle();
      check_eq("A_total_cnt", 32'(words.size()), 32'd2);
      if (words.size() > 1) check_eq("lui_word", words[1], 32'h1234_52B7);
      check_eq("empty_flush_ack", 32'(n_acks - acks0), 32'd1);

      // Misaligned 32-bit parcel, then flush of the spilled half
      words.delete();
      acks0 = n_acks;
      send(32'h0015_0513);
      send(32'h1234_52B7);
      do_flush();
      settle();
      check_eq("B_cnt", 32'(words.size()), 32'd2);
      if (words.size() > 1) begin
         check_eq("B_word0", words[0], 32'h52B7_0505);
         check_eq("B_word1", words[1], 32'h0001_1234);
      end
      check_eq("B_flush_ack", 32'(n_acks - acks0), 32'd1);

      // Single-instruction vectors; compressed ones appear padded with c.nop
      run_vec("c_nop",      32'h0000_0013, 32'h0001_0001);
      run_vec("c_addi_1",   32'h0015_0513, 32'h0001_0505);
      run_vec("c_addi_m32", 32'hFE05_0513, 32'h0001_1501);
      run_vec("addi_p32",   32'h0205_0513, 32'h0205_0513);
      run_vec("slli_0",     32'h0002_9293, 32'h0002_9293);
      run_vec("c_slli_1",   32'h0012_9293, 32'h0001_0286);
      run_vec("beq_p256",   32'h1004_0063, 32'h1004_0063);
      run_vec("c_beqz_m256", 32'hF004_00E3, 32'h0001_D001);
      run_vec("c_mv",       32'h00B0_0533, 32'h0001_852E);
      run_vec("c_sub",      32'h4094_0433, 32'h0001_8C05);
      run_vec("c_lw",       32'h0044_A403, 32'h0001_40C0);
      run_vec("c_swsp",     32'h0011_2423, 32'h0001_C406);
      run_vec("c_jr",       32'h0000_8067, 32'h0001_8082);
      run_vec("c_jal_m2",   32'hFFFF_F0EF, 32'h0001_3FFD);
      run_vec("c_li_m1",    32'hFFF0_0293, 32'h0001_52FD);
      run_vec("c_srai",     32'h4034_D493, 32'h0001_848D);
      run_vec("not_rv32",   32'h0015_0510, 32'h0015_0510);

      // Output stall: new instruction must wait, stalled word must not move
      words.delete();
      bus.word_ready_in = 1'b0;
      send(32'h1234_52B7);
      bus.inst_in       = 32'hABCD_E037;
      bus.inst_valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("stall_inst_ready", 32'(bus.inst_ready_out), 32'd0);
         check_eq("stall_word", bus.word_out, 32'h1234_52B7);
      end
      @(posedge clk);
      #1;
      bus.word_ready_in = 1'b1;
      @(posedge clk);
      #1;
      bus.inst_valid_in = 1'b0;
      settle();
      check_eq("stall_cnt", 32'(words.size()), 32'd2);
      if (words.size() > 1) begin
         check_eq("stall_word0", words[0], 32'h1234_52B7);
         check_eq("stall_word1", words[1], 32'hABCD_E037);
      end

      // Asynchronous reset discards both the stalled word and the held halfword
      words.delete();
      bus.word_ready_in = 1'b0;
      send(32'h0015_0513);
      send(32'h1234_52B7);
      check_eq("pre_rst_valid", 32'(bus.word_valid_out), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", 32'(bus.word_valid_out), 32'd0);
      check_eq("async_rst_word", bus.word_out, 32'h0);
      @(posedge clk);
      #1;
      rst_n             = 1'b1;
      bus.word_ready_in = 1'b1;
      acks0 = n_acks;
      do_flush();
      settle();
      check_eq("post_rst_no_word", 32'(words.size()), 32'd0);
      check_eq("post_rst_flush_ack", 32'(n_acks - acks0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
